// File: rtl/fp_pkg.sv
// Shared constants and types for the 8-bit float {S,E,F} to 12-bit linear decoder.
package fp_pkg;

   localparam int W_LIN = 12;
   localparam int W_EXP = 3;
   localparam int W_MAN = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SIGN  = 2'd2,
      HOLD  = 2'd3
   } fp_dec_state_t;

   typedef struct packed {
      logic             s;
      logic [W_EXP-1:0] e;
      logic [W_MAN-1:0] f;
   } fp_word_t;

   // Two's-complement negate when the sign bit is set; negative zero collapses to zero.
   function automatic logic [W_LIN-1:0] apply_sign(input logic sgn, input logic [W_LIN-1:0] mag);
      logic [W_LIN-1:0] one;
      one = {{(W_LIN-1){1'b0}}, 1'b1};
      if (sgn) begin
         return ~mag + one;
      end else begin
         return mag;
      end
   endfunction

endpackage

// File: rtl/fp_to_linear_seq.sv
// Iterative float {S,E[2:0],F[3:0]} to 12-bit two's-complement decoder, one left shift per clock.
// Optional midpoint reconstruction of the truncated bits is enabled by defining FP_MIDPOINT_RECON_EN.
module fp_to_linear_seq
   import fp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             S,
   input  logic [2:0]       E,
   input  logic [3:0]       F,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [11:0]      D,
   output logic             busy
);

   fp_dec_state_t    state_q;
   fp_word_t         word_s;
   logic [W_LIN-1:0] mag_q;
   logic [W_EXP-1:0] cnt_q;
   logic             sgn_q;
   logic [W_LIN-1:0] d_q;
   logic             out_valid_q;
   logic             in_ready_q;
   logic             busy_q;
   logic [W_LIN-1:0] mag_final_d;
   logic [W_LIN-1:0] d_d;
`ifdef FP_MIDPOINT_RECON_EN
   logic [W_EXP-1:0] e_q;
`endif

   assign word_s = {S, E, F};

   // Final magnitude and signed result presented to D in the SIGN state.
   always_comb begin
      mag_final_d = mag_q;
`ifdef FP_MIDPOINT_RECON_EN
      if (e_q != 3'd0) begin
         mag_final_d = mag_q | (12'd1 << (e_q - 3'd1));
      end else begin
         mag_final_d = mag_q;
      end
`endif
      d_d = apply_sign(sgn_q, mag_final_d);
   end

   // Decoder FSM with all datapath and handshake outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mag_q       <= 12'd0;
         cnt_q       <= 3'd0;
         sgn_q       <= 1'b0;
         d_q         <= 12'h000;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
`ifdef FP_MIDPOINT_RECON_EN
         e_q         <= 3'd0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mag_q      <= {{(W_LIN-W_MAN){1'b0}}, word_s.f};
                  cnt_q      <= word_s.e;
                  sgn_q      <= word_s.s;
`ifdef FP_MIDPOINT_RECON_EN
                  e_q        <= word_s.e;
`endif
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= (word_s.e != 3'd0) ? SHIFT : SIGN;
               end else begin
                  state_q    <= IDLE;
               end
            end
            SHIFT: begin
               mag_q <= mag_q << 1;
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_q <= SIGN;
               end else begin
                  state_q <= SHIFT;
               end
            end
            SIGN: begin
               d_q         <= d_d;
               out_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: begin
               // No bypass to a new accept: the block always passes through IDLE.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  state_q     <= HOLD;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign D         = d_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fp_to_linear_seq.sv
// Directed self-checking bench for fp_to_linear_seq; expectations follow FP_MIDPOINT_RECON_EN.
module tb_fp_to_linear_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        S;
   logic [2:0]  E;
   logic [3:0]  F;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] D;
   logic        busy;

   int tests;
   int fails;

`ifdef FP_MIDPOINT_RECON_EN
   localparam logic [11:0] EXP_MAX = 12'd1984;
   localparam logic [11:0] EXP_NEG = 12'hFD4;
   localparam logic [11:0] EXP_BP  = 12'd50;
   localparam logic [11:0] EXP_B2A = 12'd3;
   localparam logic [11:0] EXP_B2B = 12'hF78;
`else
   localparam logic [11:0] EXP_MAX = 12'd1920;
   localparam logic [11:0] EXP_NEG = 12'hFD8;
   localparam logic [11:0] EXP_BP  = 12'd48;
   localparam logic [11:0] EXP_B2A = 12'd2;
   localparam logic [11:0] EXP_B2B = 12'hF80;
`endif

   fp_to_linear_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .S         (S),
      .E         (E),
      .F         (F),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (D),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word for a single edge, then count edges until out_valid (bounded).
   task automatic send_wait(input logic s, input logic [2:0] e, input logic [3:0] f, output int edges);
      S = s; E = e; F = f; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 30) begin
         step();
         edges++;
      end
   endtask

   task automatic wait_valid(output int edges);
      edges = 0;
      while (!out_valid && edges < 30) begin
         step();
         edges++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== 12'h000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset: out_valid=%b in_ready=%b D=%h busy=%b, want 0 1 000 0", out_valid, in_ready, D, busy);
      end
   endtask

   task automatic test_zero_exp();
      int edges;
      out_ready = 1'b1;
      send_wait(1'b0, 3'd0, 4'd9, edges);
      tests++;
      if (edges !== 2 || D !== 12'd9) begin
         fails++;
         $display("FAIL zero_exp: edges=%0d D=%0d, want 2 9", edges, D);
      end
      tests++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL zero_exp_hold: busy=%b in_ready=%b, want 1 0", busy, in_ready);
      end
      step();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || D !== 12'd9) begin
         fails++;
         $display("FAIL zero_exp_idle: out_valid=%b in_ready=%b busy=%b D=%0d, want 0 1 0 9", out_valid, in_ready, busy, D);
      end
   endtask

   task automatic test_reset_mid_shift();
      int seen;
      S = 1'b0; E = 3'd7; F = 4'd15; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== 12'h000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_shift: out_valid=%b in_ready=%b D=%h busy=%b, want 0 1 000 0", out_valid, in_ready, D, busy);
      end
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (out_valid) seen++;
      end
      tests++;
      if (seen !== 0) begin
         fails++;
         $display("FAIL reset_discard: out_valid seen %0d cycles, want 0", seen);
      end
   endtask

   task automatic test_max();
      int edges;
      out_ready = 1'b1;
      send_wait(1'b0, 3'd7, 4'd15, edges);
      tests++;
      if (edges !== 9 || D !== EXP_MAX) begin
         fails++;
         $display("FAIL max: edges=%0d D=%0d, want 9 %0d", edges, D, EXP_MAX);
      end
      step();
   endtask

   task automatic test_negative();
      int edges;
      out_ready = 1'b1;
      send_wait(1'b1, 3'd3, 4'd5, edges);
      tests++;
      if (edges !== 5 || D !== EXP_NEG) begin
         fails++;
         $display("FAIL negative: edges=%0d D=%h, want 5 %h", edges, D, EXP_NEG);
      end
      step();
      send_wait(1'b1, 3'd0, 4'd0, edges);
      tests++;
      if (edges !== 2 || D !== 12'h000) begin
         fails++;
         $display("FAIL neg_zero: edges=%0d D=%h, want 2 000", edges, D);
      end
      step();
   endtask

   task automatic test_backpressure();
      int edges;
      int bad;
      out_ready = 1'b0;
      send_wait(1'b0, 3'd2, 4'd12, edges);
      tests++;
      if (edges !== 4 || D !== EXP_BP) begin
         fails++;
         $display("FAIL bp_result: edges=%0d D=%0d, want 4 %0d", edges, D, EXP_BP);
      end
      S = 1'b1; E = 3'd5; F = 4'd3; in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (out_valid !== 1'b1 || D !== EXP_BP || in_ready !== 1'b0) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL bp_hold: %0d unstable cycles, want 0 (D=%0d out_valid=%b in_ready=%b)", bad, D, out_valid, in_ready);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || D !== EXP_BP) begin
         fails++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b D=%0d, want 0 1 0 %0d", out_valid, in_ready, busy, D, EXP_BP);
      end
      step();
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL bp_ignored: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      int edges;
      int guard;
      out_ready = 1'b1;
      S = 1'b0; E = 3'd1; F = 4'd1; in_valid = 1'b1;
      step();
      S = 1'b1; E = 3'd4; F = 4'd8;
      wait_valid(edges);
      tests++;
      if (edges !== 2 || D !== EXP_B2A) begin
         fails++;
         $display("FAIL b2b_first: edges_after_accept=%0d D=%h, want 2 %h", edges, D, EXP_B2A);
      end
      guard = 0;
      while (!in_ready && guard < 30) begin
         step();
         guard++;
      end
      step();
      in_valid = 1'b0;
      wait_valid(edges);
      tests++;
      if (edges !== 5 || D !== EXP_B2B) begin
         fails++;
         $display("FAIL b2b_second: edges_after_accept=%0d D=%h, want 5 %h", edges, D, EXP_B2B);
      end
      step();
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL b2b_drain: out_valid=%b busy=%b, want 0 0", out_valid, busy);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      S = 1'b0;
      E = 3'd0;
      F = 4'd0;
      test_reset();
      test_zero_exp();
      test_reset_mid_shift();
      test_max();
      test_negative();
      test_backpressure();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
